// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load handshake.
// Each word becomes WIDTH bits, each bit held CLKS_PER_BIT clocks, and frames can run back to back.
module piso_serializer #(
    parameter int WIDTH        = 8,
    parameter int MSB_FIRST    = 0,
    parameter int CLKS_PER_BIT = 1,
    parameter bit IDLE_LEVEL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_bit,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W     = $clog2(WIDTH);
    localparam int DIV_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int FIRST_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             out_bit_reg, out_bit_next;
    logic             busy_reg, busy_next;

    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] run_word;
    logic             last_clk;
    logic             accept;

    // The shift register holds only the bits not yet driven; the next one sits at FIRST_IDX.
    // load_word is the incoming word with its first bit already removed.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST != 0) begin : g_left
            if (gi == 0) begin : g_fill
                assign load_word[gi] = 1'b0;
                assign run_word[gi]  = 1'b0;
            end else begin : g_move
                assign load_word[gi] = in_data[gi-1];
                assign run_word[gi]  = shift_reg[gi-1];
            end
        end else begin : g_right
            if (gi == WIDTH - 1) begin : g_fill
                assign load_word[gi] = 1'b0;
                assign run_word[gi]  = 1'b0;
            end else begin : g_move
                assign load_word[gi] = in_data[gi+1];
                assign run_word[gi]  = shift_reg[gi+1];
            end
        end
    end

    assign last_clk   = (state_reg == SHIFT) && (bit_cnt_reg == BIT_LAST) && (div_reg == DIV_LAST);
    assign in_ready   = rst && ((state_reg == IDLE) || last_clk);
    assign frame_done = rst && last_clk;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        div_next     = div_reg;
        out_bit_next = out_bit_reg;
        busy_next    = busy_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next   = SHIFT;
                    shift_next   = load_word;
                    bit_cnt_next = '0;
                    div_next     = '0;
                    out_bit_next = in_data[FIRST_IDX];
                    busy_next    = 1'b1;
                end
            end
            SHIFT: begin
                if (div_reg != DIV_LAST) begin
                    div_next = div_reg + 1'b1;
                end else if (bit_cnt_reg != BIT_LAST) begin
                    div_next     = '0;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    out_bit_next = shift_reg[FIRST_IDX];
                    shift_next   = run_word;
                end else if (accept) begin
                    // Chain the next frame with no idle cycle in between.
                    shift_next   = load_word;
                    bit_cnt_next = '0;
                    div_next     = '0;
                    out_bit_next = in_data[FIRST_IDX];
                    busy_next    = 1'b1;
                end else begin
                    state_next   = IDLE;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    div_next     = '0;
                    out_bit_next = IDLE_LEVEL;
                    busy_next    = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_reg     <= '0;
            out_bit_reg <= IDLE_LEVEL;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            div_reg     <= div_next;
            out_bit_reg <= out_bit_next;
            busy_reg    <= busy_next;
        end
    end

    assign out_bit = out_bit_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: five configurations share clk and rst. Each one is checked
// cycle by cycle against a per-cycle {out_bit, busy, in_ready, frame_done} prediction.
module tb_piso_serializer;

    localparam int CW [5] = '{8, 8, 8, 2, 32};
    localparam int CM [5] = '{0, 1, 0, 0, 1};
    localparam int CC [5] = '{1, 1, 3, 2, 2};
    localparam bit CI [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v  [5];
    logic [63:0] d  [5];
    logic        ob [5];
    logic        bz [5];
    logic        rd [5];
    logic        fd [5];

    int          total = 0;
    int          bad   = 0;
    logic [63:0] wq [16];
    logic [3:0]  cap [$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(d[0][7:0]), .in_ready(rd[0]),
        .out_bit(ob[0]), .busy(bz[0]), .frame_done(fd[0]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(d[1][7:0]), .in_ready(rd[1]),
        .out_bit(ob[1]), .busy(bz[1]), .frame_done(fd[1]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .CLKS_PER_BIT(3), .IDLE_LEVEL(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_valid(v[2]), .in_data(d[2][7:0]), .in_ready(rd[2]),
        .out_bit(ob[2]), .busy(bz[2]), .frame_done(fd[2]));
    piso_serializer #(.WIDTH(2), .MSB_FIRST(0), .CLKS_PER_BIT(2), .IDLE_LEVEL(1'b0)) u_d (
        .clk(clk), .rst(rst), .in_valid(v[3]), .in_data(d[3][1:0]), .in_ready(rd[3]),
        .out_bit(ob[3]), .busy(bz[3]), .frame_done(fd[3]));
    piso_serializer #(.WIDTH(32), .MSB_FIRST(1), .CLKS_PER_BIT(2), .IDLE_LEVEL(1'b0)) u_e (
        .clk(clk), .rst(rst), .in_valid(v[4]), .in_data(d[4][31:0]), .in_ready(rd[4]),
        .out_bit(ob[4]), .busy(bz[4]), .frame_done(fd[4]));

    function automatic logic [3:0] obs(int i);
        return {ob[i], bz[i], rd[i], fd[i]};
    endfunction

    // Cycle j counts from the edge that takes wq[0]; the words in wq are sent back to back.
    // Cycle 0 is the idle cycle just before that edge.
    function automatic logic [3:0] exp_vec(int i, int n, int j);
        int   len, f, p, k, idx;
        logic b, last;
        len = CW[i] * CC[i];
        if (j == 0 || j > n * len) return {CI[i], 3'b010};
        f    = (j - 1) / len;
        p    = (j - 1) % len;
        k    = p / CC[i];
        idx  = (CM[i] != 0) ? CW[i] - 1 - k : k;
        b    = wq[f][idx];
        last = (p == len - 1);
        return {b, 1'b1, last, last};
    endfunction

    // Stimulus only: offers wq[0..n-1] on DUT i, each one exactly when the previous frame ends.
    // It records the outputs of every cycle into cap. With junk set, random valid/data are
    // driven while in_ready is expected low.
    task automatic play(input int i, input int n, input bit junk);
        int len;
        len = CW[i] * CC[i];
        cap = {};
        v[i] = 1'b1;
        d[i] = wq[0];
        #1;
        cap.push_back(obs(i));
        for (int j = 1; j <= n * len + 1; j++) begin
            @(negedge clk);
            cap.push_back(obs(i));
            if (j % len == 0 && j / len < n) begin
                v[i] = 1'b1;
                d[i] = wq[j / len];
            end else if (junk && j < n * len) begin
                v[i] = 1'($urandom_range(0, 1));
                d[i] = {$urandom, $urandom};
            end else begin
                v[i] = 1'b0;
            end
        end
        v[i] = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            exp = {CI[i], 3'b000};
            total++;
            if (obs(i) !== exp) begin
                bad++;
                $display("FAIL reset_hold dut%0d: got %b want %b", i, obs(i), exp);
            end
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            exp = {CI[i], 3'b010};
            total++;
            if (obs(i) !== exp) begin
                bad++;
                $display("FAIL reset_release dut%0d: got %b want %b", i, obs(i), exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_frame;
        wq[0] = 64'h1E;
        play(0, 1, 1'b0);
        for (int j = 0; j < cap.size(); j++) begin
            total++;
            if (cap[j] !== exp_vec(0, 1, j)) begin
                bad++;
                $display("FAIL lsb_frame cycle %0d: got %b want %b", j, cap[j], exp_vec(0, 1, j));
            end
        end
        // The same frame against the literal bit pattern 0,1,1,1,1,0,0,0.
        for (int j = 1; j <= 8; j++) begin
            total++;
            if (cap[j][3] !== ((j >= 2 && j <= 5) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL lsb_pattern cycle %0d: got %b", j, cap[j][3]);
            end
        end
    endtask

    task automatic test_msb_idle;
        wq[0] = 64'h1E;
        wq[1] = {$urandom, $urandom};
        play(1, 2, 1'b0);
        for (int j = 0; j < cap.size(); j++) begin
            total++;
            if (cap[j] !== exp_vec(1, 2, j)) begin
                bad++;
                $display("FAIL msb_idle cycle %0d: got %b want %b", j, cap[j], exp_vec(1, 2, j));
            end
        end
    endtask

    task automatic test_bit_period;
        wq[0] = 64'h1E;
        wq[1] = {$urandom, $urandom};
        play(2, 2, 1'b1);
        for (int j = 0; j < cap.size(); j++) begin
            total++;
            if (cap[j] !== exp_vec(2, 2, j)) begin
                bad++;
                $display("FAIL bit_period cycle %0d: got %b want %b", j, cap[j], exp_vec(2, 2, j));
            end
        end
    endtask

    task automatic test_back_to_back;
        wq[0] = 64'h1E;
        wq[1] = 64'hC3;
        for (int k = 2; k < 5; k++) wq[k] = {$urandom, $urandom};
        play(0, 5, 1'b1);
        for (int j = 0; j < cap.size(); j++) begin
            total++;
            if (cap[j] !== exp_vec(0, 5, j)) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", j, cap[j], exp_vec(0, 5, j));
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        wq[0] = 64'hFF;
        v[0] = 1'b1;
        d[0] = 64'hFF;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            v[0] = 1'b0;
            total++;
            if (obs(0) !== exp_vec(0, 1, j)) begin
                bad++;
                $display("FAIL mid_reset_pre cycle %0d: got %b want %b", j, obs(0), exp_vec(0, 1, j));
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs(0) !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_abort: got %b want 0000", obs(0));
        end
        rst = 1'b1;
        wq[0] = {$urandom, $urandom};
        play(0, 1, 1'b0);
        for (int j = 0; j < cap.size(); j++) begin
            total++;
            if (cap[j] !== exp_vec(0, 1, j)) begin
                bad++;
                $display("FAIL mid_reset_after cycle %0d: got %b want %b", j, cap[j], exp_vec(0, 1, j));
            end
        end
    endtask

    task automatic test_width_sweep;
        for (int k = 0; k < 6; k++) wq[k] = {$urandom, $urandom};
        play(3, 6, 1'b1);
        for (int j = 0; j < cap.size(); j++) begin
            total++;
            if (cap[j] !== exp_vec(3, 6, j)) begin
                bad++;
                $display("FAIL width2 cycle %0d: got %b want %b", j, cap[j], exp_vec(3, 6, j));
            end
        end
        for (int k = 0; k < 3; k++) wq[k] = {$urandom, $urandom};
        play(4, 3, 1'b1);
        for (int j = 0; j < cap.size(); j++) begin
            total++;
            if (cap[j] !== exp_vec(4, 3, j)) begin
                bad++;
                $display("FAIL width32 cycle %0d: got %b want %b", j, cap[j], exp_vec(4, 3, j));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
        test_reset;
        test_lsb_frame;
        test_msb_idle;
        test_bit_period;
        test_back_to_back;
        test_reset_mid_frame;
        test_width_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
